// File: rtl/dot_product_accumulator_if.sv
// Product-in / dot-product-out handshake bundle.
// master drives product, in_valid and out_ready.
interface dot_product_accumulator_if #(
  parameter int N     = 8,
  parameter int LEN   = 4,
  parameter int ACC_W = 2*N+$clog2(LEN)+1,
  parameter int CW    = $clog2(LEN+1)
);
  logic [2*N-1:0]   product;
  logic             in_valid;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic             out_valid;
  logic             out_ready;
  logic [CW-1:0]    term_cnt;

  modport master (
    output product, in_valid, out_ready,
    input  in_ready, acc_out, out_valid, term_cnt
  );

  modport slave (
    input  product, in_valid, out_ready,
    output in_ready, acc_out, out_valid, term_cnt
  );
endinterface

// File: rtl/dot_product_accumulator.sv
// Accumulates LEN signed products into one dot product.
// DOT_OVERLAP_EN: accept the next term during the result transfer.
module dot_product_accumulator #(
  parameter int N     = 8,
  parameter int LEN   = 4,
  parameter int ACC_W = 2*N+$clog2(LEN)+1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  dot_product_accumulator_if.slave bus
);
  localparam int CW = $clog2(LEN+1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             in_rdy, out_vld;
  logic             accept, xfer;
  logic [ACC_W-1:0] ext;

  assign ext = {{(ACC_W-2*N){bus.product[2*N-1]}},
                bus.product};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    in_rdy  = 1'b1;
    out_vld = 1'b0;
    if (state_q == HOLD) begin
      out_vld = 1'b1;
`ifdef DOT_OVERLAP_EN
      in_rdy  = bus.out_ready;
`else
      in_rdy  = 1'b0;
`endif
    end
    accept = bus.in_valid && in_rdy;
    xfer   = out_vld && bus.out_ready;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d   = ext;
            cnt_d   = CW'(1);
            state_d = (LEN == 1) ? HOLD : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_d = acc_q + ext;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(LEN-1))
              state_d = HOLD;
          end
        end
        HOLD: begin
          if (xfer) begin
            acc_d   = '0;
            cnt_d   = '0;
            state_d = IDLE;
`ifdef DOT_OVERLAP_EN
            if (accept) begin
              acc_d   = ext;
              cnt_d   = CW'(1);
              state_d = (LEN == 1) ? HOLD : ACCUM;
            end
`endif
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = out_vld;
  assign bus.acc_out   = acc_q;
  assign bus.term_cnt  = cnt_q;
endmodule
